// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the main-bus round-robin arbiter.
package bus_rr_arbiter_pkg;

    localparam int NUM_MASTERS      = 4;
    localparam int ARB_TIMEOUT_CLKS = 12;
    localparam int ARB_STROBE_LEN   = 1;
    localparam int ERR_COUNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        RELEASE,
        ERR
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
        return (&value) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module rr_priority_select #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from ptr_i+1 through ptr_i itself; the first request hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= N; off++) begin
            cand     = (int'(ptr_i) + off) % N;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o           = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and transaction sequencer for the shared 16-bit main bus.
// Sequence per transaction: grant -> ADDR (wait for dev_sel) -> STROBE -> RELEASE.
module bus_rr_arbiter #(
    parameter  int NUM_MASTERS  = bus_rr_arbiter_pkg::NUM_MASTERS,
    parameter  int TIMEOUT_CLKS = bus_rr_arbiter_pkg::ARB_TIMEOUT_CLKS,
    parameter  int STROBE_LEN   = bus_rr_arbiter_pkg::ARB_STROBE_LEN,
    localparam int IDX_W        = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] barq_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    input  logic                   address_valid_i,
    output logic [NUM_MASTERS-1:0] bagd_o,
    output logic                   target_ready_o,
    output logic                   data_strobe_o,
    output logic                   error_o,
    output logic                   busy_o,
    output logic [7:0]             err_count_o,
    output logic [IDX_W-1:0]       owner_o
);

    import bus_rr_arbiter_pkg::*;

    // Counter values at which ADDR times out and STROBE ends.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] STROBE_LAST  = 8'(STROBE_LEN - 1);
    localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] bagd_q, bagd_d;
    logic                   target_ready_q, target_ready_d;
    logic                   data_strobe_q, data_strobe_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;
    logic [7:0]             err_count_q, err_count_d;
    logic [IDX_W-1:0]       owner_q, owner_d;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   owner_req;
    logic                   owner_lock;

    // The owner register doubles as the round-robin pointer.
    rr_priority_select #(.N(NUM_MASTERS)) u_pick (
        .req_i   (barq_i),
        .ptr_i   (owner_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign owner_req  = barq_i[owner_q];
    assign owner_lock = lock_i[owner_q];

    // Next-state and next-output logic; every output is computed one cycle ahead.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bagd_d         = bagd_q;
        target_ready_d = target_ready_q;
        data_strobe_d  = data_strobe_q;
        error_d        = 1'b0;
        err_count_d    = err_count_q;
        owner_d        = owner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d        = pick_idx;
                    bagd_d         = pick_onehot;
                    target_ready_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                // A decode in the last allowed cycle still beats the timeout.
                if (address_valid_i) begin
                    data_strobe_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = STROBE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    error_d        = 1'b1;
                    err_count_d    = sat_inc(err_count_q);
                    bagd_d         = '0;
                    target_ready_d = 1'b0;
                    state_d        = ERR;
                end else if (!owner_req) begin
                    target_ready_d = 1'b0;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    data_strobe_d  = 1'b0;
                    target_ready_d = 1'b0;
                    state_d        = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: begin
                // A locked owner keeps its grant and skips arbitration.
                if (owner_lock && owner_req) begin
                    target_ready_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = ADDR;
                end else begin
                    bagd_d  = '0;
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                bagd_d         = '0;
                target_ready_d = 1'b0;
                data_strobe_d  = 1'b0;
                state_d        = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bagd_q         <= '0;
            target_ready_q <= 1'b0;
            data_strobe_q  <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
            err_count_q    <= '0;
            owner_q        <= OWNER_RST;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bagd_q         <= bagd_d;
            target_ready_q <= target_ready_d;
            data_strobe_q  <= data_strobe_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
            err_count_q    <= err_count_d;
            owner_q        <= owner_d;
        end
    end

    assign bagd_o         = bagd_q;
    assign target_ready_o = target_ready_q;
    assign data_strobe_o  = data_strobe_q;
    assign error_o        = error_q;
    assign busy_o         = busy_q;
    assign err_count_o    = err_count_q;
    assign owner_o        = owner_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (4 masters, timeout 12, strobe 1).
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] barq_i = '0;
    logic [3:0] lock_i = '0;
    logic       address_valid_i = 1'b0;
    logic [3:0] bagd_o;
    logic       target_ready_o;
    logic       data_strobe_o;
    logic       error_o;
    logic       busy_o;
    logic [7:0] err_count_o;
    logic [1:0] owner_o;

    int checks = 0;
    int errors = 0;
    int onehot_bad = 0;

    bus_rr_arbiter #(
        .NUM_MASTERS  (4),
        .TIMEOUT_CLKS (12),
        .STROBE_LEN   (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .barq_i          (barq_i),
        .lock_i          (lock_i),
        .address_valid_i (address_valid_i),
        .bagd_o          (bagd_o),
        .target_ready_o  (target_ready_o),
        .data_strobe_o   (data_strobe_o),
        .error_o         (error_o),
        .busy_o          (busy_o),
        .err_count_o     (err_count_o),
        .owner_o         (owner_o)
    );

    always #5 clk = ~clk;

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        if (!rst && !$onehot0(bagd_o)) onehot_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [3:0] barq;
        logic [3:0] lock;
        logic       av;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Output packing: {bagd, target_ready, strobe, error, busy, err_count, owner}.
    function automatic logic [17:0] pk(input logic [3:0] bagd, input logic tr, input logic ds,
                                       input logic er, input logic bs, input logic [7:0] ec,
                                       input logic [1:0] ow);
        return {bagd, tr, ds, er, bs, ec, ow};
    endfunction

    function automatic logic [17:0] outs();
        return {bagd_o, target_ready_o, data_strobe_o, error_o, busy_o, err_count_o, owner_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic [3:0] barq, input logic [3:0] lock,
                       input logic av, input logic [17:0] exp);
        vec_t v;
        v.name = name; v.barq = barq; v.lock = lock; v.av = av; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic build_table();
        int order[6] = '{0, 1, 3, 0, 1, 3};
        logic [3:0] oh;
        logic [1:0] ow;
        // Fairness: 1011 held, every transaction decodes immediately.
        for (int i = 0; i < 6; i++) begin
            oh = 4'b0001 << order[i];
            ow = 2'(order[i]);
            add("fair_grant",   4'b1011, 4'b0000, 1'b1, pk(oh,      1, 0, 0, 1, 8'd0, ow));
            add("fair_strobe",  4'b1011, 4'b0000, 1'b1, pk(oh,      1, 1, 0, 1, 8'd0, ow));
            add("fair_release", 4'b1011, 4'b0000, 1'b1, pk(oh,      0, 0, 0, 1, 8'd0, ow));
            add("fair_idle",    4'b1011, 4'b0000, 1'b1, pk(4'b0000, 0, 0, 0, 0, 8'd0, ow));
        end
        // Single request, decode two cycles into ADDR.
        add("single_grant",   4'b0001, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd0, 2'd0));
        add("single_wait",    4'b0001, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd0, 2'd0));
        add("single_strobe",  4'b0001, 4'b0000, 1'b1, pk(4'b0001, 1, 1, 0, 1, 8'd0, 2'd0));
        add("single_release", 4'b0000, 4'b0000, 1'b1, pk(4'b0001, 0, 0, 0, 1, 8'd0, 2'd0));
        add("single_idle",    4'b0000, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd0, 2'd0));
        // Timeout on master 0; late requests from 1 and 2 are ignored until IDLE.
        add("to_grant",       4'b0001, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd0, 2'd0));
        for (int i = 0; i < 11; i++)
            add("to_wait",    4'b0111, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd0, 2'd0));
        add("to_error",       4'b0111, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 1, 1, 8'd1, 2'd0));
        add("to_idle",        4'b0111, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd0));
        add("to_next_grant",  4'b0111, 4'b0000, 1'b0, pk(4'b0010, 1, 0, 0, 1, 8'd1, 2'd1));
        add("to_next_strobe", 4'b0010, 4'b0000, 1'b1, pk(4'b0010, 1, 1, 0, 1, 8'd1, 2'd1));
        add("to_next_rel",    4'b0000, 4'b0000, 1'b0, pk(4'b0010, 0, 0, 0, 1, 8'd1, 2'd1));
        add("to_next_idle",   4'b0000, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd1));
        // Decode arriving on the last allowed ADDR cycle.
        add("bnd_grant",      4'b0001, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd1, 2'd0));
        for (int i = 0; i < 11; i++)
            add("bnd_wait",   4'b0001, 4'b0000, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd1, 2'd0));
        add("bnd_strobe",     4'b0001, 4'b0000, 1'b1, pk(4'b0001, 1, 1, 0, 1, 8'd1, 2'd0));
        add("bnd_release",    4'b0000, 4'b0000, 1'b0, pk(4'b0001, 0, 0, 0, 1, 8'd1, 2'd0));
        add("bnd_idle",       4'b0000, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd0));
        // Master abort: request dropped in ADDR, no strobe, no error.
        add("abort_grant",    4'b0100, 4'b0000, 1'b0, pk(4'b0100, 1, 0, 0, 1, 8'd1, 2'd2));
        add("abort_release",  4'b0000, 4'b0000, 1'b0, pk(4'b0100, 0, 0, 0, 1, 8'd1, 2'd2));
        add("abort_idle",     4'b0000, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd2));
        // Lock: three back-to-back transactions on master 0, then master 2.
        add("lock_grant",     4'b0101, 4'b0001, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd1, 2'd0));
        for (int i = 0; i < 3; i++) begin
            add("lock_strobe",  4'b0101, 4'b0001, 1'b1, pk(4'b0001, 1, 1, 0, 1, 8'd1, 2'd0));
            add("lock_release", 4'b0101, 4'b0001, 1'b1, pk(4'b0001, 0, 0, 0, 1, 8'd1, 2'd0));
            if (i < 2)
                add("lock_readdr", 4'b0101, 4'b0001, 1'b0, pk(4'b0001, 1, 0, 0, 1, 8'd1, 2'd0));
        end
        add("lock_drop_idle", 4'b0100, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd0));
        add("lock_m2_grant",  4'b0100, 4'b0000, 1'b0, pk(4'b0100, 1, 0, 0, 1, 8'd1, 2'd2));
        add("lock_m2_strobe", 4'b0100, 4'b0000, 1'b1, pk(4'b0100, 1, 1, 0, 1, 8'd1, 2'd2));
        add("lock_m2_rel",    4'b0000, 4'b0000, 1'b0, pk(4'b0100, 0, 0, 0, 1, 8'd1, 2'd2));
        add("lock_m2_idle",   4'b0000, 4'b0000, 1'b0, pk(4'b0000, 0, 0, 0, 0, 8'd1, 2'd2));
    endtask

    initial begin
        int pulses;
        int budget;
        logic [7:0] model_cnt;

        build_table();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(outs()), 32'(pk(4'b0000, 0, 0, 0, 0, 8'd0, 2'd3)));
        rst = 1'b0;

        // Directed vector table, one clock per row.
        foreach (vecs[i]) begin
            barq_i          = vecs[i].barq;
            lock_i          = vecs[i].lock;
            address_valid_i = vecs[i].av;
            step();
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // 300 consecutive timeouts on master 0: counter saturates at 255.
        barq_i = 4'b0001; lock_i = '0; address_valid_i = 1'b0;
        pulses = 0;
        model_cnt = 8'd1;
        budget = 300 * 14 + 100;
        while (pulses < 300 && budget > 0) begin
            step();
            budget--;
            if (error_o) begin
                pulses++;
                if (model_cnt != 8'd255) model_cnt = model_cnt + 8'd1;
                check("sat_err_count", 32'(err_count_o), 32'(model_cnt));
            end
        end
        check("sat_pulses", 32'(pulses), 32'd300);
        check("sat_final_count", 32'(err_count_o), 32'd255);
        barq_i = 4'b0000;
        step();
        step();
        check("sat_idle", 32'(outs()), 32'(pk(4'b0000, 0, 0, 0, 0, 8'd255, 2'd0)));

        // Asynchronous reset while STROBE is high.
        barq_i = 4'b0010; address_valid_i = 1'b1;
        step();
        check("ar_grant", 32'(outs()), 32'(pk(4'b0010, 1, 0, 0, 1, 8'd255, 2'd1)));
        step();
        check("ar_strobe", 32'(outs()), 32'(pk(4'b0010, 1, 1, 0, 1, 8'd255, 2'd1)));
        #2 rst = 1'b1;
        #1 check("ar_async_clear", 32'(outs()), 32'(pk(4'b0000, 0, 0, 0, 0, 8'd0, 2'd3)));
        @(negedge clk);
        check("ar_held", 32'(outs()), 32'(pk(4'b0000, 0, 0, 0, 0, 8'd0, 2'd3)));
        rst = 1'b0;
        barq_i = 4'b0011; address_valid_i = 1'b0;
        step();
        check("ar_first_grant", 32'(outs()), 32'(pk(4'b0001, 1, 0, 0, 1, 8'd0, 2'd0)));

        check("grant_onehot0", 32'(onehot_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared 16-bit main bus.
- Grants bus ownership to one of NUM_MASTERS requesters (USB interface on index 0, others reserved).
- Sequences each transaction: address phase, target-select wait, data strobe, release.
- Enforces a select timeout, reports errors and counts them. Runs in the clk100 domain next to the address decoder and dev_sel register.

Parameters:
- NUM_MASTERS, 4, number of requesters; barq_i/bagd_o width.
- TIMEOUT_CLKS, 12, cycles allowed in ADDR for address_valid_i before timeout; range 2..255.
- STROBE_LEN, 1, cycles data_strobe_o stays high per transaction; range 1..4.

Ports:
- clk  in  1  bus clock (clk100).
- rst  in  1  asynchronous reset, active-high.
- barq_i  in  NUM_MASTERS  bus access request, one bit per master; level, held until the master sees data_strobe_o.
- lock_i  in  NUM_MASTERS  master keeps the bus for back-to-back transactions.
- address_valid_i  in  1  OR of the registered dev_sel: a target has decoded the address.
- bagd_o  out  NUM_MASTERS  bus grant, one-hot or zero.
- target_ready_o  out  1  high during ADDR/STROBE; low clears dev_sel asynchronously in the decoder.
- data_strobe_o  out  1  write/read data qualifier.
- error_o  out  1  one-cycle pulse on timeout.
- busy_o  out  1  high when state is not IDLE.
- err_count_o  out  8  saturating timeout counter.
- owner_o  out  $clog2(NUM_MASTERS)  index of the last/current granted master.

Behaviour:
- Reset values: bagd_o=0, target_ready_o=0, data_strobe_o=0, error_o=0, busy_o=0, err_count_o=0, owner_o=NUM_MASTERS-1, state IDLE.
- All outputs are registered.
- Round-robin search starts at (owner+1) mod N and wraps. Master 0 wins first after reset.
- IDLE: if any barq_i is high, the winner is latched into owner. Next cycle: bagd_o=onehot(owner), target_ready_o=1, counter=0, state ADDR. Grant latency is 1 cycle.
- ADDR: the counter increments each cycle.
  - If address_valid_i=1, go to STROBE.
  - Else if the counter reaches TIMEOUT_CLKS-1, go to ERR.
  - Else if barq_i[owner]=0 (master abort), go to RELEASE without a strobe and without an error.
  - If address_valid_i and the timeout occur in the same cycle, address_valid_i wins.
- STROBE: data_strobe_o=1 for exactly STROBE_LEN cycles, with target_ready_o and bagd_o held. Then go to RELEASE.
- RELEASE: lasts 1 cycle with target_ready_o=0 and data_strobe_o=0.
  - If lock_i[owner]=1 and barq_i[owner]=1, re-enter ADDR with the same grant and counter=0. No rearbitration.
  - Otherwise drop bagd_o and go to IDLE.
  - Arbitration from IDLE happens the following cycle, so there is at least 1 idle cycle between different owners.
- ERR: lasts 1 cycle. error_o=1, err_count_o increments (saturating at 255), bagd_o=0, target_ready_o=0, then IDLE. The owner pointer advances, so a faulty master cannot starve others.
- Requests that change in ADDR or STROBE from non-owners are ignored until IDLE.
- bagd_o never has more than one bit set. bagd_o=0 whenever target_ready_o has been low for 2+ cycles outside RELEASE→ADDR.
- Reset mid-transaction: all outputs return to reset values immediately (async). No strobe completes.

Decomposition:
- Shared package (Skeleton_package) holds:
  - NUM_MASTERS, ARB_TIMEOUT_CLKS and ARB_STROBE_LEN defaults.
  - typedef enum arb_state_t {IDLE, ADDR, STROBE, RELEASE, ERR}.
- One sub-module is natural: rr_priority_select. It is a combinational round-robin picker taking a request vector and a pointer, and returning one-hot plus index.

Test Plan:
- Single request: barq_i=0001 with address_valid_i rising 2 cycles into ADDR.
  - Expect bagd_o=0001 one cycle after the request and data_strobe_o high for 1 cycle.
  - Expect target_ready_o low in RELEASE and bagd_o=0 afterwards. error_o stays 0.
- Fairness: barq_i=1011 held, each transaction completes.
  - Expect grant order 0,1,3,0,1,3 with one idle cycle between owners.
- Timeout: barq_i=0001, address_valid_i never asserts.
  - Expect error_o pulse exactly 12 cycles after grant, err_count_o=1, bagd_o=0.
  - Next grant goes to the next requester in order.
- Lock: barq_i=0001, lock_i=0001 with barq_i[2] also high.
  - Expect 3 back-to-back transactions on master 0 separated by single RELEASE cycles, then master 2 is granted after the lock drops.
- Boundary: address_valid_i rises exactly on counter=11 → strobe occurs and no error.
  - Also drive 300 consecutive timeouts → err_count_o saturates at 255.
- Async reset asserted during STROBE: all outputs go to 0 in the same cycle without waiting for a clock edge. After release, owner_o=3 and the first grant goes to master 0.
